// File: rtl/priority_arbiter.sv
// priority_arbiter: registered N-way arbiter with a valid/ready grant handshake.
// Each grant picks either fixed priority (bit N-1 highest) or round-robin from
// an internal pointer. A grant is held stable until the consumer accepts it,
// and back-to-back grants issue one per cycle while requests keep arriving.
module priority_arbiter #(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          mode,
    input  logic          grant_ready,
    output logic          grant_valid,
    output logic [IW-1:0] grant_idx,
    output logic [N-1:0]  grant_onehot
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t          state, state_n;
    logic [IW-1:0]   ptr, ptr_n;
    logic            mode_q, mode_n;
    logic [IW-1:0]   idx_n;
    logic [N-1:0]    onehot_n;

    logic [IW-1:0]   ptr_accept;   // pointer value after accepting the held grant
    logic [IW-1:0]   ptr_eff;      // pointer the winner search uses this cycle
    logic [N-1:0]    rr_mask;      // request bits at or below ptr_eff
    logic [IW-1:0]   winner;
    logic            accept;

    // Highest-index set bit of v; returns 0 when v is empty.
    function automatic logic [IW-1:0] highest_set(input logic [N-1:0] v);
        logic [IW-1:0] idx;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) idx = IW'(i);
        end
        return idx;
    endfunction

    assign accept = (state == HOLD) && grant_ready;

    // Pointer update: the next round-robin search starts just below the grant
    // that completed, wrapping from 0 to N-1; fixed-mode grants leave it alone.
    always_comb begin
        ptr_accept = ptr;
        if (mode_q) begin
            ptr_accept = (grant_idx == '0) ? IW'(N - 1) : grant_idx - IW'(1);
        end
        ptr_eff = accept ? ptr_accept : ptr;
    end

    // Winner search. Round-robin scans ptr_eff down to 0, then wraps to N-1:
    // the highest set bit at or below ptr_eff wins, and if there is none, the
    // highest set bit overall (necessarily above ptr_eff) wins.
    always_comb begin
        rr_mask = '0;
        for (int i = 0; i < N; i++) begin
            rr_mask[i] = (i <= int'(ptr_eff));
        end
        if (mode && |(req & rr_mask)) begin
            winner = highest_set(req & rr_mask);
        end else begin
            winner = highest_set(req);
        end
    end

    // Next-state and next-output logic for the IDLE/HOLD handshake.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_n  = state;
        ptr_n    = ptr;
        mode_n   = mode_q;
        idx_n    = grant_idx;
        onehot_n = grant_onehot;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_n  = HOLD;
                    mode_n   = mode;
                    idx_n    = winner;
                    onehot_n = {{(N-1){1'b0}}, 1'b1} << winner;
                end
            end
            HOLD: begin
                if (grant_ready) begin
                    ptr_n = ptr_accept;
                    if (|req) begin
                        mode_n   = mode;
                        idx_n    = winner;
                        onehot_n = {{(N-1){1'b0}}, 1'b1} << winner;
                    end else begin
                        state_n  = IDLE;
                        onehot_n = '0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers; reset discards any pending grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ptr          <= IW'(N - 1);
            mode_q       <= 1'b0;
            grant_idx    <= '0;
            grant_onehot <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state        <= state_n;
            ptr          <= ptr_n;
            mode_q       <= mode_n;
            grant_idx    <= idx_n;
            grant_onehot <= onehot_n;
        end
    end

    assign grant_valid = (state == HOLD);

endmodule

// File: tb/tb_priority_arbiter.sv
// tb_priority_arbiter: directed vectors with hand-computed expectations for
// priority_arbiter at N=8, plus hand-written stall and async-reset sequences.
module tb_priority_arbiter;

    localparam int N  = 8;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req;
    logic          mode;
    logic          grant_ready;
    logic          grant_valid;
    logic [IW-1:0] grant_idx;
    logic [N-1:0]  grant_onehot;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [N-1:0]  req;
        logic          mode;
        logic          ready;
        logic          exp_valid;
        logic [IW-1:0] exp_idx;
        logic [N-1:0]  exp_onehot;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs[NV];

    priority_arbiter #(.N(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .mode         (mode),
        .grant_ready  (grant_ready),
        .grant_valid  (grant_valid),
        .grant_idx    (grant_idx),
        .grant_onehot (grant_onehot)
    );

    always #5 clk = ~clk;

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Apply inputs, take one rising edge, then compare outputs 1 time unit later.
    task automatic step(input string name, input logic [N-1:0] r, input logic m, input logic rdy,
                        input logic ev, input logic [IW-1:0] ei, input logic [N-1:0] eo);
        req         = r;
        mode        = m;
        grant_ready = rdy;
        @(posedge clk);
        #1;
        check({name, ".valid"},  32'(grant_valid),  32'(ev));
        check({name, ".idx"},    32'(grant_idx),    32'(ei));
        check({name, ".onehot"}, 32'(grant_onehot), 32'(eo));
    endtask

    initial begin
        //               req          mode  rdy   valid idx   onehot
        vecs[0]  = '{8'b0101_0000, 1'b0, 1'b1, 1'b1, 3'd6, 8'h40};
        vecs[1]  = '{8'b1000_1001, 1'b0, 1'b1, 1'b1, 3'd7, 8'h80};
        vecs[2]  = '{8'h00,        1'b0, 1'b1, 1'b0, 3'd7, 8'h00};
        vecs[3]  = '{8'h00,        1'b0, 1'b1, 1'b0, 3'd7, 8'h00};
        vecs[4]  = '{8'hFF,        1'b1, 1'b1, 1'b1, 3'd7, 8'h80};
        vecs[5]  = '{8'hFF,        1'b1, 1'b1, 1'b1, 3'd6, 8'h40};
        vecs[6]  = '{8'hFF,        1'b1, 1'b1, 1'b1, 3'd5, 8'h20};
        vecs[7]  = '{8'hFF,        1'b1, 1'b1, 1'b1, 3'd4, 8'h10};
        vecs[8]  = '{8'hFF,        1'b1, 1'b1, 1'b1, 3'd3, 8'h08};
        vecs[9]  = '{8'hFF,        1'b1, 1'b1, 1'b1, 3'd2, 8'h04};
        vecs[10] = '{8'hFF,        1'b1, 1'b1, 1'b1, 3'd1, 8'h02};
        vecs[11] = '{8'hFF,        1'b1, 1'b1, 1'b1, 3'd0, 8'h01};
        vecs[12] = '{8'hFF,        1'b1, 1'b1, 1'b1, 3'd7, 8'h80};
        vecs[13] = '{8'b1000_1001, 1'b1, 1'b1, 1'b1, 3'd3, 8'h08};
        vecs[14] = '{8'b1000_1001, 1'b1, 1'b1, 1'b1, 3'd0, 8'h01};
        vecs[15] = '{8'b1000_1001, 1'b1, 1'b1, 1'b1, 3'd7, 8'h80};
        vecs[16] = '{8'b1000_1001, 1'b1, 1'b1, 1'b1, 3'd3, 8'h08};
        vecs[17] = '{8'b1000_1001, 1'b0, 1'b1, 1'b1, 3'd7, 8'h80};
        vecs[18] = '{8'b1000_1001, 1'b0, 1'b1, 1'b1, 3'd7, 8'h80};
        vecs[19] = '{8'b1000_1001, 1'b0, 1'b1, 1'b1, 3'd7, 8'h80};
        vecs[20] = '{8'h00,        1'b0, 1'b1, 1'b0, 3'd7, 8'h00};
        vecs[21] = '{8'b0000_0100, 1'b0, 1'b0, 1'b1, 3'd2, 8'h04};
        vecs[22] = '{8'h00,        1'b0, 1'b0, 1'b1, 3'd2, 8'h04};
        vecs[23] = '{8'h00,        1'b0, 1'b1, 1'b0, 3'd2, 8'h00};

        rst_n       = 1'b0;
        req         = '0;
        mode        = 1'b0;
        grant_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.valid",  32'(grant_valid),  32'd0);
        check("reset.idx",    32'(grant_idx),    32'd0);
        check("reset.onehot", 32'(grant_onehot), 32'd0);
        #2 rst_n = 1'b1;

        // Fixed priority, idle, round-robin dense and sparse, back to fixed, empty.
        for (int v = 0; v < NV; v++) begin
            step($sformatf("vec%0d", v), vecs[v].req, vecs[v].mode, vecs[v].ready,
                 vecs[v].exp_valid, vecs[v].exp_idx, vecs[v].exp_onehot);
        end

        // Stall: grant 6 held while ready is low and req/mode change underneath.
        step("stall.grant",  8'b0101_0000, 1'b0, 1'b0, 1'b1, 3'd6, 8'h40);
        for (int c = 0; c < 3; c++) begin
            step($sformatf("stall.hold%0d", c), 8'b1000_0000, 1'b1, 1'b0, 1'b1, 3'd6, 8'h40);
        end
        step("stall.accept", 8'b1000_0000, 1'b0, 1'b1, 1'b1, 3'd7, 8'h80);
        step("stall.idle",   8'h00,        1'b0, 1'b1, 1'b0, 3'd7, 8'h00);

        // Async reset in mid-HOLD, away from any clock edge.
        step("rst.grant3", 8'b0000_1000, 1'b0, 1'b0, 1'b1, 3'd3, 8'h08);
        #2 rst_n = 1'b0;
        #1;
        check("rst.async.valid",  32'(grant_valid),  32'd0);
        check("rst.async.idx",    32'(grant_idx),    32'd0);
        check("rst.async.onehot", 32'(grant_onehot), 32'd0);
        req         = 8'hFF;
        mode        = 1'b1;
        grant_ready = 1'b1;
        #1 rst_n = 1'b1;
        step("rst.rr_first",  8'hFF, 1'b1, 1'b1, 1'b1, 3'd7, 8'h80);
        step("rst.rr_second", 8'hFF, 1'b1, 1'b1, 1'b1, 3'd6, 8'h40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
